// File: rtl/jt49_pcm.sv
// Converts the PSG's 10-bit unsigned mix into a decimated, DC-free, signed 16-bit PCM stream.
// Pipeline: window box average, leaky-integrator DC removal, one-entry valid/ready output register.
module jt49_pcm #(
  parameter int DECIM_W  = 5,
  parameter int DC_SHIFT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [9:0]  sound,
  input  logic        mute,
  output logic [15:0] pcm,
  output logic        pcm_valid,
  input  logic        pcm_ready,
  output logic        overrun
);

  localparam int AW = 10 + DECIM_W;
  localparam int DW = 10 + DC_SHIFT;
  localparam logic [DECIM_W-1:0] CNT_MAX = '1;
  localparam logic [DECIM_W-1:0] CNT_ONE = DECIM_W'(1);

  logic [AW-1:0]      acc_r;
  logic [AW-1:0]      sum_s;
  logic [DECIM_W-1:0] cnt_r;
  logic [9:0]         avg_r;
  logic               win_done_r;

  logic [DW-1:0]      dc_r;
  logic [DW-1:0]      dc_next_s;
  logic [9:0]         mean_s;
  logic signed [10:0] diff_s;
  logic               primed_r;
  logic               s1_fire_r;
  logic [15:0]        s1_pcm_r;

  logic [15:0]        pcm_r;
  logic               pcm_valid_r;
  logic               overrun_r;

  // Window sum and DC-tracker arithmetic; the full window sum never exceeds AW bits.
  always_comb begin
    sum_s     = acc_r + {{DECIM_W{1'b0}}, sound};
    mean_s    = dc_r[DW-1:DC_SHIFT];
    diff_s    = $signed({1'b0, avg_r}) - $signed({1'b0, mean_s});
    dc_next_s = dc_r - {{DC_SHIFT{1'b0}}, mean_s} + {{DC_SHIFT{1'b0}}, avg_r};
  end

  // Stage 0: accumulate sound over 2^DECIM_W cen ticks, then publish the truncated average.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r      <= '0;
      cnt_r      <= '0;
      avg_r      <= 10'd0;
      win_done_r <= 1'b0;
    end else if (cen) begin
      if (cnt_r == CNT_MAX) begin
        avg_r      <= sum_s[AW-1:DECIM_W];
        acc_r      <= '0;
        cnt_r      <= '0;
        win_done_r <= 1'b1;
      end else begin
        acc_r      <= sum_s;
        cnt_r      <= cnt_r + CNT_ONE;
        win_done_r <= 1'b0;
      end
    end else begin
      win_done_r <= 1'b0;
    end
  end

  // Stage 1: the first window seeds the integrator so the stream starts at zero instead of a DC step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_r      <= '0;
      primed_r  <= 1'b0;
      s1_fire_r <= 1'b0;
      s1_pcm_r  <= 16'd0;
    end else if (win_done_r) begin
      s1_fire_r <= 1'b1;
      if (!primed_r) begin
        dc_r     <= {avg_r, {DC_SHIFT{1'b0}}};
        primed_r <= 1'b1;
        s1_pcm_r <= 16'd0;
      end else begin
        dc_r     <= dc_next_s;
        s1_pcm_r <= mute ? 16'd0 : {diff_s, 5'b00000};
      end
    end else begin
      s1_fire_r <= 1'b0;
    end
  end

  // Stage 2: one-entry output register; a sample arriving while full and stalled is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm_r       <= 16'd0;
      pcm_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else if (s1_fire_r) begin
      if (!pcm_valid_r || pcm_ready) begin
        pcm_r       <= s1_pcm_r;
        pcm_valid_r <= 1'b1;
      end else begin
        overrun_r   <= 1'b1;
      end
    end else if (pcm_valid_r && pcm_ready) begin
      pcm_valid_r <= 1'b0;
    end else begin
      pcm_valid_r <= pcm_valid_r;
    end
  end

  assign pcm       = pcm_r;
  assign pcm_valid = pcm_valid_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_jt49_pcm.sv
// Bench for jt49_pcm: table of windows with hand-derived PCM values checked through a scoreboard,
// plus sequences for latency, cen gating, backpressure, asynchronous reset and the widest window.
module tb_jt49_pcm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen;
  logic [9:0]  sound;
  logic        mute;
  logic        pcm_ready;
  logic [15:0] pcm;
  logic        pcm_valid;
  logic        overrun;

  logic        cen8;
  logic [9:0]  sound8;
  logic [15:0] pcm8;
  logic        pcm8_valid;
  logic        overrun8;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  logic signed [15:0] sb[$];

  typedef struct {
    bit              rst;
    logic [3:0][9:0] s;
    bit              mu;
    int              exp;
  } vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  jt49_pcm #(.DECIM_W(2), .DC_SHIFT(2)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .sound(sound), .mute(mute),
    .pcm(pcm), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .overrun(overrun)
  );

  jt49_pcm #(.DECIM_W(8), .DC_SHIFT(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .cen(cen8), .sound(sound8), .mute(1'b0),
    .pcm(pcm8), .pcm_valid(pcm8_valid), .pcm_ready(1'b1), .overrun(overrun8)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // inputs change 2 ns after a rising edge and are sampled by the next one
  task automatic tick(input logic c, input logic [9:0] s);
    cen   = c;
    sound = s;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    cen   = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic win(input logic [9:0] s, input bit push, input int e);
    for (int k = 0; k < 4; k++) begin
      if (k == 3 && push) sb.push_back(16'(e));
      tick(1'b1, s);
    end
    for (int k = 0; k < 3; k++) tick(1'b0, 10'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cen = 1'b0; sound = 10'd0; mute = 1'b0; pcm_ready = 1'b1;
    cen8 = 1'b0; sound8 = 10'd0;

    vecs[0] = '{1'b1, {10'd5,   10'd2,   10'd1,   10'd0},   1'b0, 0};
    vecs[1] = '{1'b1, {10'd400, 10'd400, 10'd400, 10'd400}, 1'b0, 0};
    vecs[2] = '{1'b0, {10'd400, 10'd400, 10'd400, 10'd400}, 1'b0, 0};
    vecs[3] = '{1'b0, {10'd600, 10'd600, 10'd600, 10'd600}, 1'b0, 6400};
    vecs[4] = '{1'b0, {10'd600, 10'd600, 10'd600, 10'd600}, 1'b0, 4800};
    vecs[5] = '{1'b0, {10'd600, 10'd600, 10'd600, 10'd600}, 1'b0, 3616};
    vecs[6] = '{1'b0, {10'd200, 10'd200, 10'd200, 10'd200}, 1'b1, 0};
    vecs[7] = '{1'b0, {10'd200, 10'd200, 10'd200, 10'd200}, 1'b0, -7584};
    vecs[8] = '{1'b0, {10'd204, 10'd203, 10'd202, 10'd201}, 1'b0, -5600};

    fork
      forever begin
        logic signed [15:0] e;
        @(negedge clk);
        if (pcm_valid) valid_cnt++;
        if (rst_n && pcm_valid && pcm_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_sample", int'($signed(pcm)), 99999);
          end else begin
            e = sb.pop_front();
            chk("pcm_sample", int'($signed(pcm)), int'(e));
          end
        end
      end
    join_none

    #12;
    chk("reset_pcm", int'(pcm), 0);
    chk("reset_valid", int'(pcm_valid), 0);
    chk("reset_overrun", int'(overrun), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].rst) do_reset();
      mute = vecs[i].mu;
      for (int k = 0; k < 4; k++) begin
        if (k == 3) sb.push_back(16'(vecs[i].exp));
        tick(1'b1, vecs[i].s[k]);
      end
      chk("valid_at_T", int'(pcm_valid), 0);
      tick(1'b0, 10'd0);
      chk("valid_at_T1", int'(pcm_valid), 0);
      tick(1'b0, 10'd0);
      chk("valid_at_T2", int'(pcm_valid), 1);
      tick(1'b0, 10'd0);
    end
    mute = 1'b0;
    chk("table_drained", sb.size(), 0);

    // cen every third clock: three 12-clock windows, one sample each
    do_reset();
    valid_cnt = 0;
    for (int i = 0; i < 36; i++) begin
      if (i % 3 == 0) begin
        if ((i / 3) % 4 == 3) sb.push_back(16'sd0);
        tick(1'b1, 10'd300);
      end else begin
        tick(1'b0, 10'd300);
      end
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 10'd300);
    chk("cen_gated_windows", valid_cnt, 3);
    valid_cnt = 0;
    for (int i = 0; i < 40; i++) tick(1'b0, 10'd900);
    chk("cen_low_quiet", valid_cnt, 0);
    chk("cen_drained", sb.size(), 0);

    // backpressure: hold, accept-on-arrival, then drop with overrun
    do_reset();
    win(10'd300, 1'b1, 0);
    pcm_ready = 1'b0;
    win(10'd500, 1'b1, 6400);
    chk("bp_hold_pcm", int'($signed(pcm)), 6400);
    chk("bp_hold_valid", int'(pcm_valid), 1);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) sb.push_back(16'sd4800);
      tick(1'b1, 10'd500);
    end
    tick(1'b0, 10'd0);
    pcm_ready = 1'b1;
    tick(1'b0, 10'd0);
    pcm_ready = 1'b0;
    chk("arrive_pcm", int'($signed(pcm)), 4800);
    chk("arrive_valid", int'(pcm_valid), 1);
    chk("arrive_no_overrun", int'(overrun), 0);
    win(10'd500, 1'b0, 0);
    chk("drop_overrun", int'(overrun), 1);
    chk("drop_pcm_held", int'($signed(pcm)), 4800);
    chk("drop_valid_held", int'(pcm_valid), 1);
    pcm_ready = 1'b1;
    tick(1'b0, 10'd0);
    chk("drain_valid", int'(pcm_valid), 0);
    chk("drain_pcm_kept", int'($signed(pcm)), 4800);
    chk("bp_drained", sb.size(), 0);

    // asynchronous reset in mid-window with full-scale input
    tick(1'b1, 10'd1023);
    tick(1'b1, 10'd1023);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pcm", int'(pcm), 0);
    chk("async_rst_valid", int'(pcm_valid), 0);
    chk("async_rst_overrun", int'(overrun), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    win(10'd100, 1'b1, 0);
    win(10'd300, 1'b1, 6400);
    chk("post_rst_drained", sb.size(), 0);

    // widest window: 256 ticks of full scale must average to 1023
    cen8 = 1'b1;
    sound8 = 10'd0;
    repeat (256) @(posedge clk);
    #2;
    sound8 = 10'd1023;
    repeat (256) @(posedge clk);
    #2;
    cen8 = 1'b0;
    n = 0;
    while (!pcm8_valid && n < 8) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("w8_latency", n, 2);
    chk("w8_full_scale", int'($signed(pcm8)), 32736);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt49_pcm.md
# jt49_pcm

Post-processing stage that consumes the 10-bit unsigned `sound` mix produced by the jt49 PSG core and turns it into a decimated, DC-free, signed 16-bit PCM stream for the downstream audio path. It box-averages `sound` over a window of 2^DECIM_W clock-enable ticks and removes the DC offset with a leaky integrator. Samples are presented on a valid/ready interface with a one-entry output register.

## Interface
Parameters:
- `DECIM_W`, default 5: decimation window is 2^DECIM_W `cen` ticks. Legal range is 1..8.
- `DC_SHIFT`, default 8: DC integrator time constant, 2^DC_SHIFT output samples. Legal range is 1..12.

Ports:
- `clk`  in  1: system clock; the block acts on the positive edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `cen`  in  1: clock enable, the same strobe that drives the PSG `clk_en`.
- `sound`  in  10: unsigned PSG mix, sampled when `cen`=1.
- `mute`  in  1: forces the emitted sample value to 0.
- `pcm`  out  16: signed PCM sample.
- `pcm_valid`  out  1: `pcm` holds an untransferred sample.
- `pcm_ready`  in  1: consumer accepts the sample.
- `overrun`  out  1: sticky flag; a sample was dropped because of backpressure.

## Operation
Stage 0, window accumulator:
- `acc` is 10+DECIM_W bits wide. `cnt` is DECIM_W bits wide.
- On `cen`=1 and `cnt` below its maximum: `acc += sound` and `cnt++`.
- On `cen`=1 and `cnt` at its maximum:
  - `avg <= (acc + sound) >> DECIM_W`, 10 bits, truncated.
  - `acc <= 0` and `cnt <= 0`.
  - Pulse `win_done` for one clk.
- When `cen`=0, the accumulator and counter hold.

Stage 1, DC removal. This stage runs on `clk` and is not gated by `cen`; it fires on the cycle after `win_done`.
- `dc` is 10+DC_SHIFT bits, unsigned. `mean = dc >> DC_SHIFT`.
- `primed` is a 1-bit flag, cleared by reset.
- When `primed`=0:
  - `dc <= avg << DC_SHIFT`, `diff = 0`, `primed <= 1`.
- When `primed`=1:
  - `diff = avg - mean`, an 11-bit signed value computed with the old `dc`.
  - `dc <= dc - mean + avg`.
- Sample value is `{diff, 5'b0}`, giving a range of −32736..+32736. No saturation is needed.
- When `mute`=1, the sample value is 0. `dc` still updates normally.

Stage 2, output register. It is loaded on the cycle after stage 1 fires (`s1_fire`):
- If `pcm_valid`=0, or `pcm_ready`=1 in the same cycle: load `pcm` and set `pcm_valid`=1.
- Otherwise the new sample is dropped, `pcm` and `pcm_valid` hold, and `overrun <= 1`.
- On `pcm_valid && pcm_ready` with no new sample arriving: `pcm_valid <= 0`. `pcm` retains its last value.
- `overrun` is cleared only by reset.

## Timing
- All registers reset to 0: `acc`, `cnt`, `avg`, `dc`, `primed`, `pcm`, `pcm_valid`, `overrun`.
- Asserting `rst_n` mid-window discards the partial sum; after release the window restarts at `cnt`=0.
- Latency from the final `cen` tick of a window (edge T):
  - `avg` is valid after T.
  - Stage 1 computes at T+1.
  - `pcm_valid` rises at edge T+2.
- With `cen` high continuously, samples are spaced 2^DECIM_W clk apart. The minimum spacing is 2 clk at DECIM_W=1; the pipeline sustains one sample per window.
- `pcm` and `pcm_valid` are registered outputs, with no combinational path from `pcm_ready`.
- A sample is accepted on any edge where `pcm_valid && pcm_ready`.
- `mute` is sampled in stage 1 only.

## Test plan
All scenarios use DECIM_W=2 and DC_SHIFT=2 unless noted.
- **Reset:** assert `rst_n`=0 asynchronously mid-window with `sound`=1023 -> `pcm`=0, `pcm_valid`=0, `overrun`=0 immediately. The first post-reset window sums exactly 4 new ticks.
- **Averaging:** `sound` = 0,1,2,5 on four consecutive `cen` ticks, `cen` high continuously -> `avg`=2, first output `pcm`=0 (priming), `pcm_valid` high 2 clk after the 4th tick.
- **DC step:**
  - Primed with constant 400: outputs are 0.
  - Step to a constant 600:
    - First window -> `pcm`=6400 (diff 200), `dc`=1800.
    - Next window -> `pcm`=4800 (diff 150).
    - The output decays toward 0.
- **cen gating:** `cen` pulses every 3rd clk with constant `sound` -> windows take 12 clk, with exactly one `pcm_valid` per window. Holding `cen` low produces no samples.
- **Backpressure:** `pcm_ready`=0 across two windows -> the first sample is held and the second is dropped, `overrun`=1. Then `pcm_ready`=1 -> the first sample transfers and `pcm_valid` drops.
  - Variant: `pcm_ready`=1 in the arrival cycle -> the new sample loads, `pcm_valid` stays 1, and there is no overrun.
- **Mute / extremes:**
  - `mute`=1 with a step input -> `pcm`=0 while `dc` keeps tracking. Releasing `mute` after convergence gives ~0.
  - With DECIM_W=8 and `sound`=1023 constant -> `avg`=1023 with no overflow.
